// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: eight-digit multiplexed seven-segment scan controller.
//
// Cycles through eight digits in SHOW/GUARD slots driven by an external
// digit-advance tick, with GUARD_CYC blanking cycles between digits to
// suppress ghosting. Display contents are loaded through a valid/ready
// handshake into a shadow register and copied into the active register only
// at the 7->0 wrap, so every frame shows one consistent load.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits (digit 0 is always lit; a lit decimal point keeps its digit on).
//
// All outputs are registered; their next values are decoded from the
// next-state values so outputs line up with the state register.

module seg_scan_ctrl #(
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        en,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    input  logic [7:0]  ld_dp,
    output logic        ld_ready,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [2:0]  digit_sel,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  gcnt_q, gcnt_d;
    logic [2:0]  digit_q, digit_d;
    logic        frame_d;

    logic [31:0] act_data_q, act_data_d;
    logic [7:0]  act_dp_q, act_dp_d;
    logic [31:0] shd_data_q, shd_data_d;
    logic [7:0]  shd_dp_q, shd_dp_d;
    logic        pending_q, pending_d;

    logic [7:0]  lit;
    logic [7:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;

    logic [7:0]  an_q;
    logic [6:0]  seg_q;
    logic        dp_q;
    logic        frame_q;
    logic        ready_q;

    // Standard hex to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Scan FSM, guard counter, digit index and load handshake next-state.
    always_comb begin
        state_d    = state_q;
        gcnt_d     = gcnt_q;
        digit_d    = digit_q;
        frame_d    = 1'b0;
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        shd_data_d = shd_data_q;
        shd_dp_d   = shd_dp_q;
        pending_d  = pending_q;

        // Accept a new load only while nothing is waiting for the wrap.
        if (ld_valid && !pending_q) begin
            shd_data_d = ld_data;
            shd_dp_d   = ld_dp;
            pending_d  = 1'b1;
        end

        if (!en) begin
            // Disable wins over everything; digit index is kept for resume.
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_GUARD;
                    gcnt_d  = '0;
                end
                ST_GUARD: begin
                    if (gcnt_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                    end else begin
                        gcnt_d = gcnt_q + 4'd1;
                    end
                end
                ST_SHOW: begin
                    if (tick) begin
                        state_d = ST_GUARD;
                        gcnt_d  = '0;
                        digit_d = digit_q + 3'd1;
                        if (digit_q == 3'd7) begin
                            frame_d = 1'b1;
                            // Pending and new-load acceptance are exclusive,
                            // so the swap never races a shadow capture.
                            if (pending_q) begin
                                act_data_d = shd_data_q;
                                act_dp_d   = shd_dp_q;
                                pending_d  = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    // Per-digit lit mask; leading-zero blanking scans from the top digit down.
    always_comb begin
        lit = '1;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic upper_zero;
            upper_zero = 1'b1;
            for (int unsigned k = 7; k >= 1; k--) begin
                upper_zero = upper_zero && (act_data_d[{k[2:0], 2'b00} +: 4] == 4'h0);
                lit[k[2:0]] = !(upper_zero && !act_dp_d[k[2:0]]);
            end
        end
`endif
    end

    // Output decode from next-state values so registered outputs track state.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW && lit[digit_d]) begin
            an_d[digit_d] = 1'b0;
            seg_d         = hex_to_seg(act_data_d[{digit_d, 2'b00} +: 4]);
            dp_d          = ~act_dp_d[digit_d];
        end
    end

    // State, data and output registers; reset discards all display data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_GUARD;
            gcnt_q     <= '0;
            digit_q    <= '0;
            act_data_q <= '0;
            act_dp_q   <= '0;
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            pending_q  <= 1'b0;
            an_q       <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            frame_q    <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            digit_q    <= digit_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
            shd_data_q <= shd_data_d;
            shd_dp_q   <= shd_dp_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            frame_q    <= frame_d;
            ready_q    <= !pending_d;
        end
    end

    assign ld_ready   = ready_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit_sel  = digit_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Testbench for seg_scan_ctrl: directed scan/load/enable/reset scenarios with
// a slot scoreboard. Stimulus pushes the expected digit slots; a monitor pops
// one entry each time a new anode slot lights up and compares it.

module tb_seg_scan_ctrl;

    localparam int GUARD = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        en;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [7:0]  ld_dp;
    logic        ld_ready;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_sel;
    logic        frame_done;

    seg_scan_ctrl #(.GUARD_CYC(GUARD)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .en         (en),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_dp      (ld_dp),
        .ld_ready   (ld_ready),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] dig;
        int         gap;
    } slot_t;

    slot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    frames = 0;
    bit    prev_lit = 1'b1;

    function automatic logic [6:0] hexseg(input logic [3:0] v);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    function automatic bit nonblank(input logic [31:0] d, input logic [7:0] p, input int i);
        logic [31:0] upper;
        upper = d >> (4 * i);
        return (i == 0) || p[i] || (upper != 32'h0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Push expected slots for digits from..to of a frame showing d/p.
    task automatic push_slots(input logic [31:0] d, input logic [7:0] p,
                              input int from, input int to, input int gap0);
        slot_t       s;
        logic [31:0] sh;
        logic [7:0]  one;
        bit          lit;
        one = 8'h01;
        for (int i = from; i <= to; i++) begin
            lit = !LZB || nonblank(d, p, i);
            if (lit) begin
                sh    = d >> (4 * i);
                s.an  = ~(one << i);
                s.seg = hexseg(sh[3:0]);
                s.dp  = ~p[i];
                s.dig = 3'(i);
                s.gap = (i == from && gap0 >= 0) ? gap0 : (prev_lit ? GUARD : 0);
                exp_q.push_back(s);
            end
            prev_lit = lit;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_tick();
        wait_cyc(11);
        tick = 1'b1;
        wait_cyc(1);
        tick = 1'b0;
    endtask

    // Real tick followed immediately by one that lands in GUARD.
    task automatic tick_ghost();
        do_tick();
        tick = 1'b1;
        wait_cyc(1);
        tick = 1'b0;
    endtask

    task automatic load(input logic [31:0] d, input logic [7:0] p);
        ld_data  = d;
        ld_dp    = p;
        ld_valid = 1'b1;
        wait_cyc(1);
        ld_valid = 1'b0;
    endtask

    // Monitor: compare each newly lit slot and count blank cycles before it.
    logic [7:0] prev_an = 8'hFF;
    int         gap = 0;
    always @(negedge clk) begin
        slot_t s;
        if (reset) begin
            gap     = 0;
            prev_an = 8'hFF;
        end else begin
            if (an != 8'hFF && prev_an == 8'hFF) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_slot actual an=%h required=no slot t=%0t", an, $time);
                end else begin
                    s = exp_q.pop_front();
                    check("slot_an", 32'(an), 32'(s.an));
                    check("slot_seg", 32'(seg), 32'(s.seg));
                    check("slot_dp", 32'(dp), 32'(s.dp));
                    check("slot_digit", 32'(digit_sel), 32'(s.dig));
                    if (s.gap > 0) check("slot_gap", 32'(gap), 32'(s.gap));
                end
            end
            if (an == 8'hFF) begin
                if (en) gap++;
            end else begin
                gap = 0;
            end
            if (frame_done) begin
                frames++;
                check("frame_done_digit", 32'(digit_sel), 32'h0);
            end
            prev_an = an;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        en       = 1'b1;
        tick     = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_dp    = '0;
        wait_cyc(2);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_digit", 32'(digit_sel), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h1);

        // Frame 1: blank active register, ghost tick in GUARD must be ignored.
        push_slots(32'h0, 8'h00, 0, 7, GUARD);
        reset = 1'b0;
        tick_ghost();
        repeat (6) do_tick();
        push_slots(32'h0, 8'h00, 0, 7, -1);
        do_tick();
        wait_cyc(3);
        check("frames_after_f1", 32'(frames), 32'd1);
        check("digit_after_wrap", 32'(digit_sel), 32'h0);

        // Frame 2: load mid-frame, second load while pending is ignored.
        do_tick();
        wait_cyc(6);
        load(32'h1234_ABCD, 8'h01);
        check("ready_after_load", 32'(ld_ready), 32'h0);
        load(32'h5555_5555, 8'hFF);
        check("ready_ignored_load", 32'(ld_ready), 32'h0);
        repeat (6) do_tick();
        check("ready_before_wrap", 32'(ld_ready), 32'h0);
        push_slots(32'h1234_ABCD, 8'h01, 0, 3, -1);
        do_tick();
        wait_cyc(3);
        check("ready_after_wrap", 32'(ld_ready), 32'h1);
        check("frames_after_f2", 32'(frames), 32'd2);

        // Frame 3: disable at digit 3 with ticks, resume at same digit.
        repeat (3) do_tick();
        wait_cyc(6);
        en = 1'b0;
        repeat (10) begin
            wait_cyc(9);
            tick = 1'b1;
            wait_cyc(1);
            tick = 1'b0;
        end
        check("off_an", 32'(an), 32'hFF);
        check("off_digit", 32'(digit_sel), 32'h3);
        check("off_frames", 32'(frames), 32'd2);
        push_slots(32'h1234_ABCD, 8'h01, 3, 7, GUARD + 1);
        en = 1'b1;
        do_tick();
        wait_cyc(6);
        load(32'h0000_0042, 8'h00);
        check("ready_load3", 32'(ld_ready), 32'h0);
        repeat (3) do_tick();
        push_slots(32'h0000_0042, 8'h00, 0, 3, -1);
        do_tick();
        wait_cyc(3);
        check("frames_after_f3", 32'(frames), 32'd3);
        check("ready_after_f3", 32'(ld_ready), 32'h1);

        // Frame 4: pending load then asynchronous reset mid-frame.
        repeat (3) do_tick();
        wait_cyc(6);
        load(32'hFFFF_FFFF, 8'hFF);
        check("ready_load4", 32'(ld_ready), 32'h0);
        do_tick();
        #2 reset = 1'b1;
        #1;
        check("arst_an", 32'(an), 32'hFF);
        check("arst_seg", 32'(seg), 32'h7F);
        check("arst_dp", 32'(dp), 32'h1);
        check("arst_ready", 32'(ld_ready), 32'h1);
        check("arst_digit", 32'(digit_sel), 32'h0);
        push_slots(32'h0, 8'h00, 0, 7, GUARD);
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        check("ready_post_reset", 32'(ld_ready), 32'h1);
        repeat (7) do_tick();
        wait_cyc(8);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
